// File: rtl/initiator_node_pkg.sv
`default_nettype none
// ==== initiator_node_pkg : shared FSM state types and bus widths (rev 1.0) ====
package initiator_node_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        INI_IDLE,
        INI_WR,
        INI_RD,
        INI_DONE
    } ini_state_t;

    typedef enum logic [2:0] {
        PRT_IDLE,
        PRT_REQ,
        PRT_ADDR,
        PRT_WDATA,
        PRT_RWAIT,
        PRT_ACKWAIT
    } prt_state_t;

endpackage
`default_nettype wire

// File: rtl/initiator_node_init_port.sv
`default_nettype none
// ==== initiator_node_init_port : serial bus serializer/deserializer front-end (rev 1.0) ====
module initiator_node_init_port
    import initiator_node_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_init_req,
    input  logic              i_init_rw,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic [DATA_W-1:0] i_init_wdata,
    input  logic              i_grant,
    input  logic              i_data_in,
    input  logic              i_data_in_valid,
    input  logic              i_target_ack,
    input  logic              i_target_split,
    output logic              o_arbiter_req,
    output logic              o_data_out,
    output logic              o_data_out_valid,
    output logic              o_mode,
    output logic              o_init_ack,
    output logic              o_init_data_in_valid,
    output logic [DATA_W-1:0] o_init_data_in
);

    prt_state_t        r_state;
    prt_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rw;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_sh;
    logic              w_ack_window;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PRT_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rw    <= 1'b0;
            r_cnt   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == PRT_IDLE && i_init_req) begin
                r_addr  <= i_init_addr;
                r_wdata <= i_init_wdata;
                r_rw    <= i_init_rw;
                r_sh    <= '0;
            end
            if (r_state == PRT_ADDR || r_state == PRT_WDATA)
                r_cnt <= r_cnt + 4'd1;
            else
                r_cnt <= '0;
            // LSB arrives first, so new bits enter at the top and walk down
            if (r_state == PRT_RWAIT && i_data_in_valid)
                r_sh <= {i_data_in, r_sh[DATA_W-1:1]};
        end
    end

    always_comb begin
        w_next           = r_state;
        o_data_out       = 1'b0;
        o_data_out_valid = 1'b0;
        o_mode           = 1'b0;
        case (r_state)
            PRT_IDLE: begin
                if (i_init_req)
                    w_next = PRT_REQ;
            end
            PRT_REQ: begin
                if (i_grant)
                    w_next = PRT_ADDR;
            end
            PRT_ADDR: begin
                o_data_out_valid = 1'b1;
                o_data_out       = r_addr[r_cnt];
                if (r_cnt == 4'd15)
                    w_next = r_rw ? PRT_WDATA : PRT_RWAIT;
            end
            PRT_WDATA: begin
                o_mode           = 1'b1;
                o_data_out_valid = 1'b1;
                o_data_out       = r_wdata[r_cnt[2:0]];
                if (r_cnt[2:0] == 3'd7)
                    w_next = PRT_ACKWAIT;
            end
            PRT_RWAIT: begin
                o_mode = 1'b1;
                // a split only means "response deferred": keep waiting for the ack
                if (i_target_ack)
                    w_next = PRT_IDLE;
                else if (i_target_split)
                    w_next = PRT_RWAIT;
            end
            PRT_ACKWAIT: begin
                o_mode = 1'b1;
                if (i_target_ack)
                    w_next = PRT_IDLE;
            end
            default: w_next = PRT_IDLE;
        endcase
    end

    assign w_ack_window         = (r_state == PRT_RWAIT) || (r_state == PRT_ACKWAIT);
    assign o_arbiter_req        = (r_state != PRT_IDLE);
    assign o_init_ack           = i_target_ack & w_ack_window;
    assign o_init_data_in_valid = o_init_ack & ~r_rw;
    assign o_init_data_in       = r_sh;

endmodule
`default_nettype wire

// File: rtl/initiator_node_initiator.sv
`default_nettype none
// ==== initiator_node_initiator : fixed write-then-read transaction sequencer (rev 1.0) ====
module initiator_node_initiator
    import initiator_node_pkg::*;
#(
    parameter logic [ADDR_W-1:0] WRITE_ADDR    = 16'h0012,
    parameter logic [ADDR_W-1:0] READ_ADDR     = 16'h0034,
    parameter logic [DATA_W-1:0] MEM_INIT_DATA = 8'h3C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_trigger,
    input  logic              i_ack,
    input  logic              i_data_in_valid,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              o_req,
    output logic              o_rw,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic [DATA_W-1:0] o_read_data
);

    ini_state_t r_state;
    ini_state_t w_next;
    logic       w_rd_ack;

    assign w_rd_ack = (r_state == INI_RD) && i_ack && i_data_in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INI_IDLE;
            o_read_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_rd_ack)
                o_read_data <= i_data_in;
        end
    end

    always_comb begin
        w_next = r_state;
        o_req  = 1'b0;
        o_rw   = 1'b0;
        case (r_state)
            INI_IDLE, INI_DONE: begin
                if (i_trigger)
                    w_next = INI_WR;
            end
            INI_WR: begin
                o_req = 1'b1;
                o_rw  = 1'b1;
                if (i_ack)
                    w_next = INI_RD;
            end
            INI_RD: begin
                o_req = 1'b1;
                if (w_rd_ack)
                    w_next = INI_DONE;
            end
            default: w_next = INI_IDLE;
        endcase
    end

    assign o_addr  = (r_state == INI_RD) ? READ_ADDR : WRITE_ADDR;
    assign o_wdata = MEM_INIT_DATA;
    assign o_ready = o_req;
    assign o_done  = (r_state == INI_DONE);

endmodule
`default_nettype wire

// File: rtl/initiator_node.sv
`default_nettype none
// ==== initiator_node : transaction sequencer plus serial bus front-end (rev 1.0) ====
module initiator_node
    import initiator_node_pkg::*;
#(
    parameter logic [ADDR_W-1:0] WRITE_ADDR    = 16'h0012,
    parameter logic [ADDR_W-1:0] READ_ADDR     = 16'h0034,
    parameter logic [DATA_W-1:0] MEM_INIT_DATA = 8'h3C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic              arbiter_grant,
    output logic              arbiter_req,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              bus_mode,
    output logic              bus_init_ready,
    output logic              bus_init_rw,
    input  logic              bus_data_in,
    input  logic              bus_data_in_valid,
    input  logic              target_ack,
    input  logic              target_split,
    output logic              done,
    output logic [DATA_W-1:0] read_data_value
);

    logic              w_init_req;
    logic              w_init_rw;
    logic [ADDR_W-1:0] w_init_addr;
    logic [DATA_W-1:0] w_init_wdata;
    logic              w_init_ready;
    logic              w_init_ack;
    logic              w_init_data_in_valid;
    logic [DATA_W-1:0] w_init_data_in;

    initiator_node_initiator #(
        .WRITE_ADDR    (WRITE_ADDR),
        .READ_ADDR     (READ_ADDR),
        .MEM_INIT_DATA (MEM_INIT_DATA)
    ) u_initiator (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_trigger       (trigger),
        .i_ack           (w_init_ack),
        .i_data_in_valid (w_init_data_in_valid),
        .i_data_in       (w_init_data_in),
        .o_req           (w_init_req),
        .o_rw            (w_init_rw),
        .o_addr          (w_init_addr),
        .o_wdata         (w_init_wdata),
        .o_ready         (w_init_ready),
        .o_done          (done),
        .o_read_data     (read_data_value)
    );

    initiator_node_init_port u_init_port (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_init_req           (w_init_req),
        .i_init_rw            (w_init_rw),
        .i_init_addr          (w_init_addr),
        .i_init_wdata         (w_init_wdata),
        .i_grant              (arbiter_grant),
        .i_data_in            (bus_data_in),
        .i_data_in_valid      (bus_data_in_valid),
        .i_target_ack         (target_ack),
        .i_target_split       (target_split),
        .o_arbiter_req        (arbiter_req),
        .o_data_out           (bus_data_out),
        .o_data_out_valid     (bus_data_out_valid),
        .o_mode               (bus_mode),
        .o_init_ack           (w_init_ack),
        .o_init_data_in_valid (w_init_data_in_valid),
        .o_init_data_in       (w_init_data_in)
    );

    assign bus_init_ready = w_init_ready;
    assign bus_init_rw    = w_init_rw;

endmodule
`default_nettype wire

// File: tb/tb_initiator_node.sv
`default_nettype none
// ==== tb_initiator_node : randomized target/arbiter model with transaction-level checks (rev 1.0) ====
module tb_initiator_node;

    localparam logic [15:0] C_WR_ADDR = 16'h0012;
    localparam logic [15:0] C_RD_ADDR = 16'h0034;
    localparam logic [7:0]  C_WDATA   = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trigger = 1'b0;
    logic       arbiter_grant;
    logic       arbiter_req;
    logic       bus_data_out;
    logic       bus_data_out_valid;
    logic       bus_mode;
    logic       bus_init_ready;
    logic       bus_init_rw;
    logic       bus_data_in = 1'b0;
    logic       bus_data_in_valid = 1'b0;
    logic       target_ack = 1'b0;
    logic       target_split = 1'b0;
    logic       done;
    logic [7:0] read_data_value;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    initiator_node dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .trigger            (trigger),
        .arbiter_grant      (arbiter_grant),
        .arbiter_req        (arbiter_req),
        .bus_data_out       (bus_data_out),
        .bus_data_out_valid (bus_data_out_valid),
        .bus_mode           (bus_mode),
        .bus_init_ready     (bus_init_ready),
        .bus_init_rw        (bus_init_rw),
        .bus_data_in        (bus_data_in),
        .bus_data_in_valid  (bus_data_in_valid),
        .target_ack         (target_ack),
        .target_split       (target_split),
        .done               (done),
        .read_data_value    (read_data_value)
    );

    always #5 clk = ~clk;

    // arbiter: grant is the request delayed by one cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) arbiter_grant <= 1'b0;
        else        arbiter_grant <= arbiter_req;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        trigger           = 1'b0;
        bus_data_in       = 1'b0;
        bus_data_in_valid = 1'b0;
        target_ack        = 1'b0;
        target_split      = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_req"},   arbiter_req,        0);
        check_eq({pfx, "_dout"},  bus_data_out,       0);
        check_eq({pfx, "_valid"}, bus_data_out_valid, 0);
        check_eq({pfx, "_mode"},  bus_mode,           0);
        check_eq({pfx, "_ready"}, bus_init_ready,     0);
        check_eq({pfx, "_rw"},    bus_init_rw,        0);
        check_eq({pfx, "_done"},  done,               0);
        check_eq({pfx, "_rdv"},   read_data_value,    0);
    endtask

    // One trigger -> write + read sequence; target behaviour is randomized.
    // ph: 0 = write transaction, 1 = read transaction, 2 = sequence complete
    task automatic run_seq(input logic [7:0] resp, input bit abort_mid);
        int ph = 0;
        int addr_cnt = 0, data_cnt = 0, bits_sent = 0, txns = 0;
        int req_rise = -1, last_addr_cyc = -1, rd_start = -1;
        int split_at = -1, ack_at = -1, ack_cyc = -1, spurious_at;
        logic [15:0] a = '0;
        logic [7:0]  d = '0;
        bit prev_req = 1'b0;
        bit finished = 1'b0;

        spurious_at = cyc + 2 + $urandom_range(3, 60);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 0; k < 600 && !finished; k++) begin
            if (ack_cyc >= 0 && ack_cyc == cyc - 1) begin
                check_eq("post_ack_req",  arbiter_req, 0);
                check_eq("post_ack_mode", bus_mode,    0);
                ph++;
                addr_cnt = 0; data_cnt = 0; bits_sent = 0;
                req_rise = -1; rd_start = -1; split_at = -1; ack_at = -1; ack_cyc = -1;
            end
            check_eq("ready", bus_init_ready, (ph < 2)  ? 1 : 0);
            check_eq("rw",    bus_init_rw,    (ph == 0) ? 1 : 0);
            check_eq("done",  done,           (ph == 2) ? 1 : 0);
            if (ph == 2) begin
                clear_inputs();
                check_eq("read_data", read_data_value, resp);
                check_eq("txn_count", txns, 2);
                finished = 1'b1;
            end else begin
                if (arbiter_req && !prev_req) req_rise = cyc;
                prev_req = arbiter_req;
                if (bus_data_out_valid && !bus_mode) begin
                    if (addr_cnt == 0) check_eq("addr_latency", cyc - req_rise, 2);
                    a[addr_cnt] = bus_data_out;
                    addr_cnt++;
                    if (addr_cnt == 16) begin
                        txns++;
                        last_addr_cyc = cyc;
                        check_eq(ph == 0 ? "wr_addr" : "rd_addr", a, ph == 0 ? C_WR_ADDR : C_RD_ADDR);
                        if (ph == 1) begin
                            split_at = cyc + 1;
                            rd_start = cyc + 4;
                        end
                    end
                end else if (bus_data_out_valid && bus_mode) begin
                    if (data_cnt == 0) check_eq("wdata_gap", cyc - last_addr_cyc, 1);
                    d[data_cnt] = bus_data_out;
                    data_cnt++;
                    if (data_cnt == 8) begin
                        check_eq("wdata", d, C_WDATA);
                        ack_at = cyc + $urandom_range(1, 3);
                    end
                end
                if (split_at >= 0 && cyc == split_at + 1) begin
                    check_eq("split_req",  arbiter_req, 1);
                    check_eq("split_mode", bus_mode,    1);
                end
                if (abort_mid && ph == 0 && addr_cnt == 7) begin
                    clear_inputs();
                    rst_n = 1'b0;
                    #2;
                    check_all_zero("abort");
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                clear_inputs();
                trigger = (cyc == spurious_at);
                if (cyc == split_at) target_split = 1'b1;
                if (rd_start >= 0 && cyc >= rd_start && bits_sent < 8 && $urandom_range(0, 3) != 0) begin
                    bus_data_in_valid = 1'b1;
                    bus_data_in       = resp[bits_sent];
                    bits_sent++;
                    if (bits_sent == 8) ack_at = cyc + 1 + $urandom_range(0, 2);
                end
                if (cyc == ack_at) begin
                    target_ack = 1'b1;
                    ack_cyc    = cyc;
                end
                tick();
            end
        end
        if (!finished) check_eq("timeout", 0, 1);
    endtask

    task automatic hold_done(input logic [7:0] resp);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("done_hold", done, 1);
            check_eq("rdv_hold",  read_data_value, resp);
        end
    endtask

    initial begin
        logic [7:0] r;
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_seq(8'h96, 1'b0);
        hold_done(8'h96);
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            run_seq(r, 1'b0);
            hold_done(r);
        end

        r = 8'($urandom) | 8'h01;
        run_seq(r, 1'b1);
        run_seq(8'hA5, 1'b0);
        hold_done(8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/initiator_node.md
# initiator_node

Bus-master node that combines a fixed-sequence transaction generator (initiator) with its serial bus front-end (init port). On a trigger pulse it arbitrates for the serial bus and performs two transactions:
- a write of `MEM_INIT_DATA` to `WRITE_ADDR`;
- a read from `READ_ADDR`.

It then reports the read byte and raises `done`. It sits between the bus arbiter and the serial address/data bus shared with targets.

## Interface
Parameters:
- `WRITE_ADDR`, default 16'h0012: address of the write transaction.
- `READ_ADDR`, default 16'h0034: address of the read transaction.
- `MEM_INIT_DATA`, default 8'h3C: byte written.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `trigger` in 1: one-cycle start pulse.
- `arbiter_grant` in 1: bus granted.
- `arbiter_req` out 1: bus request.
- `bus_data_out` out 1: serial address/write-data bit.
- `bus_data_out_valid` out 1: `bus_data_out` valid this cycle.
- `bus_mode` out 1: 0 = address phase, 1 = data phase.
- `bus_init_ready` out 1: pass-through of internal `init_ready`.
- `bus_init_rw` out 1: pass-through of internal `init_rw`; 1 = write, 0 = read.
- `bus_data_in` in 1: serial read-data bit.
- `bus_data_in_valid` in 1: `bus_data_in` valid.
- `target_ack` in 1: target completion pulse.
- `target_split` in 1: target split pulse.
- `done` out 1: sequence complete (level).
- `read_data_value` out 8: byte returned by the read.

## Operation
- **Initiator FSM**: IDLE → WR (`init_req`=1, `init_rw`=1, address/data held with valids) → wait `init_ack` → RD (`init_req`=1, `init_rw`=0) → wait `init_ack` with `init_data_in_valid` → DONE.
  - On that final ack, latch `init_data_in` into `read_data_value`.
  - `done`=1 in DONE until the next `trigger`, which restarts at WR.
  - `trigger` outside IDLE/DONE is ignored.
  - Request fields stay stable until `init_ack`.
  - `init_ready`=1 from request issue until ack.
- **Port FSM**: IDLE → REQ → ADDR → (WDATA | RWAIT) → ACKWAIT → IDLE.
  - **IDLE**: latch address/data/rw while `init_req`=1; go to REQ.
  - **REQ**: `arbiter_req`=1 until transaction end. Wait for `arbiter_grant`.
  - **ADDR**: 16 cycles with `bus_mode`=0 and `bus_data_out_valid`=1. Address sent LSB first (bit i on i-th cycle).
  - **WDATA** (write): 8 cycles with `bus_mode`=1 and valid=1, data LSB first. Then ACKWAIT with `bus_mode`=1 and valid=0.
  - **RWAIT** (read): `bus_mode`=1, `bus_data_out_valid`=0.
    - Each `bus_data_in_valid` shifts `sh <= {bus_data_in, sh[7:1]}`, so the first bit received is the LSB.
    - `init_data_in` = `sh`.
  - **Exit**: leave on `target_ack`, return to IDLE, drop `arbiter_req`, `bus_mode`=0.
- **Combinational pass-throughs**:
  - `init_ack` = `target_ack` while active.
  - `init_data_in_valid` = `target_ack` & !`init_rw`.
  - `init_split_ack` = `target_split`.
  - `bus_init_ready` = `init_ready`.
  - `bus_init_rw` = `init_rw`.
- **Split**: `target_split` is informational only. `arbiter_req` stays high and the port keeps waiting in RWAIT.
- Loss of `arbiter_grant` mid-transfer is ignored; the transfer completes.

## Timing
- **Reset**: all outputs 0: `arbiter_req`, `bus_data_out`, `bus_data_out_valid`, `bus_mode`, `bus_init_ready`, `bus_init_rw`, `done`, `read_data_value`. Both FSMs return to IDLE, aborting any transaction.
- `arbiter_req` rises the cycle after the port latches the request.
- The first address bit is driven the cycle after `arbiter_grant` is sampled high.
- Write data follows the last address bit with no gap.
- `init_ack` has zero latency from `target_ack` (same cycle). A write ack produces exactly one initiator ack per pulse.
- A read ack always coincides with `init_data_in_valid`. `init_data_in_valid` is never high without ack.
- `target_ack` may arrive the cycle after the 8th `bus_data_in_valid`. `sh` must already hold the full byte in that cycle.
- The initiator issues the read request the cycle after the write ack.
- `done` rises the cycle after the read ack.

## Structure
- Shared package: state enums for initiator and port, and the constants ADDR_W=16 and DATA_W=8.
- Natural sub-modules:
  - `init_port`: serializer/deserializer FSM.
  - `initiator`: sequencer.
- The top only wires them together.

## Test plan
Test target model: `arbiter_grant` = `arbiter_req` delayed one cycle; read response 8'h96 sent LSB first 4 cycles after the read address, preceded by a `target_split` pulse.
- **Trigger after reset**: target deserializes address 0x0012 (rw=1) and data 0x3C, then address 0x0034 (rw=0).
- **Read data**: response 0x96 → `read_data_value`=0x96 and `done`=1.
- **Ack counting**: exactly one write `target_ack` and one read `target_ack`, each mirrored by `init_ack` in the same cycle. The read ack has `init_data_in_valid`=1.
- **Split**: `target_split` pulse → internal `init_split_ack` equal in every cycle. Split count = 1.
- **Pass-throughs**: `bus_init_ready`/`bus_init_rw` equal the internal signals at all times.
- **Reset mid-address-phase**: all outputs 0. A subsequent trigger completes normally.
